// File: rtl/serial_ripple_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor.
// The ovf signal exists only when SRS_SIGNED_OVF_EN is defined.
interface serial_ripple_subtractor_if #(
   parameter int N = 16
);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         bout;

`ifdef SRS_SIGNED_OVF_EN
   logic         ovf;

   modport master (
      output start,
      output a,
      output b,
      output bin,
      input  busy,
      input  done,
      input  diff,
      input  bout,
      input  ovf
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  bin,
      output busy,
      output done,
      output diff,
      output bout,
      output ovf
   );
`else
   modport master (
      output start,
      output a,
      output b,
      output bin,
      input  busy,
      input  done,
      input  diff,
      input  bout
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  bin,
      output busy,
      output done,
      output diff,
      output bout
   );
`endif

endinterface

// File: rtl/serial_ripple_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, LSB-first, D bits per clock.
// Optional signed-overflow output is enabled by defining SRS_SIGNED_OVF_EN.
module serial_ripple_subtractor #(
   parameter int N = 16,
   parameter int D = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   serial_ripple_subtractor_if.slave  bus
);

   localparam int STEPS = (D >= 1) ? (N / D) : 1;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_param
         $error("serial_ripple_subtractor: D must divide N and satisfy 1 <= D <= N");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [N-1:0]   a_sh;
   logic [N-1:0]   b_sh;
   logic [N-1:0]   res_sh;
   logic           borrow;
   logic [CW-1:0]  cnt;

   logic [N-1:0]   diff_q;
   logic           bout_q;

   logic           accept;
   logic           last_digit;
   logic [D-1:0]   dig;
   logic           borrow_next;
   logic [N-1:0]   dig_ext;
   logic [N-1:0]   res_next;

`ifdef SRS_SIGNED_OVF_EN
   logic           a_msb;
   logic           b_msb;
   logic           ovf_q;
`endif

   // A request is taken whenever no subtraction is in flight, including the DONE cycle.
   assign accept     = bus.start && (state != RUN);
   assign last_digit = (cnt == CW'(STEPS - 1));

   // Ripple full-subtractor chain across the low D bits of the operand shift registers.
   always_comb begin
      logic w;
      w   = borrow;
      dig = '0;
      for (int i = 0; i < D; i++) begin
         dig[i] = a_sh[i] ^ b_sh[i] ^ w;
         w      = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & w);
      end
      borrow_next = w;
   end

   // New digit enters the result register from the MSB end.
   always_comb begin
      dig_ext          = '0;
      dig_ext[D-1:0]   = dig;
      res_next         = (res_sh >> D) | (dig_ext << (N - D));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = bus.start ? RUN : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decoded from state and the held result registers.
   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
      bus.diff = diff_q;
      bus.bout = bout_q;
`ifdef SRS_SIGNED_OVF_EN
      bus.ovf  = ovf_q;
`endif
   end

   // Operand capture, per-digit shifting and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         res_sh <= '0;
         borrow <= bus.bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> D;
         b_sh   <= b_sh >> D;
         res_sh <= res_next;
         borrow <= borrow_next;
         cnt    <= cnt + 1'b1;
         if (last_digit) begin
            diff_q <= res_next;
            bout_q <= borrow_next;
         end
      end
   end

`ifdef SRS_SIGNED_OVF_EN
   // Operand MSBs are shifted out during RUN, so they are kept aside for the overflow term.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         a_msb <= bus.a[N-1];
         b_msb <= bus.b[N-1];
      end else if ((state == RUN) && last_digit) begin
         ovf_q <= (a_msb ^ b_msb) & (res_next[N-1] ^ a_msb);
      end
   end
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor with D=1 and D=4 instances.
// Define SRS_SIGNED_OVF_EN to also check the signed-overflow output.
module tb_serial_ripple_subtractor;

   localparam int N = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_ripple_subtractor_if #(.N(N)) bus1 ();
   serial_ripple_subtractor_if #(.N(N)) bus4 ();

   serial_ripple_subtractor #(.N(N), .D(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   serial_ripple_subtractor #(.N(N), .D(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   typedef struct packed {
      logic [N-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
      int   r;
      int   sr;
      exp_t e;
      r      = int'(a) - int'(b) - int'(bin);
      sr     = int'($signed(a)) - int'($signed(b)) - int'(bin);
      e.diff = N'(r);
      e.bout = (r < 0);
      e.ovf  = (sr > 32767) || (sr < -32768);
      return e;
   endfunction

   function automatic logic busyOf(input int which);
      return (which == 1) ? bus1.busy : bus4.busy;
   endfunction

   function automatic logic doneOf(input int which);
      return (which == 1) ? bus1.done : bus4.done;
   endfunction

   task automatic driveInputs(input int which, input logic st, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic bin);
      if (which == 1) begin
         bus1.start = st; bus1.a = a; bus1.b = b; bus1.bin = bin;
      end else begin
         bus4.start = st; bus4.a = a; bus4.b = b; bus4.bin = bin;
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic applyStimulus(input int which, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic bin);
      int guard = 0;
      driveInputs(which, 1'b1, a, b, bin);
      while (busyOf(which) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         checkOutput($sformatf("dut%0d accept timeout", which), 32'd1, 32'd0);
         driveInputs(which, 1'b0, a, b, bin);
         return;
      end
      if (which == 1) q1.push_back(model(a, b, bin));
      else            q4.push_back(model(a, b, bin));
      @(posedge clk);
      @(negedge clk);
      driveInputs(which, 1'b0, N'($urandom), N'($urandom), 1'($urandom));
   endtask

   task automatic waitDone(input int which, input int exp_cycles, input string name);
      int busy_cycles = 0;
      int guard       = 0;
      while (!doneOf(which) && guard < 200) begin
         if (busyOf(which)) busy_cycles++;
         @(negedge clk);
         guard++;
      end
      checkOutput({name, " done seen"}, 32'(doneOf(which)), 32'd1);
      checkOutput({name, " busy cycles"}, 32'(busy_cycles), 32'(exp_cycles));
   endtask

   function automatic logic [N-1:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return N'($urandom);
      endcase
   endfunction

   // Monitors: pop the oldest expectation whenever a done pulse is presented.
   always @(negedge clk) begin
      if (rst_n && bus1.done) begin
         exp_t e;
         if (q1.size() == 0) begin
            checkOutput("dut1 unexpected done", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            checkOutput("dut1 diff", 32'(bus1.diff), 32'(e.diff));
            checkOutput("dut1 bout", 32'(bus1.bout), 32'(e.bout));
            checkOutput("dut1 busy in done", 32'(bus1.busy), 32'd0);
`ifdef SRS_SIGNED_OVF_EN
            checkOutput("dut1 ovf", 32'(bus1.ovf), 32'(e.ovf));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus4.done) begin
         exp_t e;
         if (q4.size() == 0) begin
            checkOutput("dut4 unexpected done", 32'd1, 32'd0);
         end else begin
            e = q4.pop_front();
            checkOutput("dut4 diff", 32'(bus4.diff), 32'(e.diff));
            checkOutput("dut4 bout", 32'(bus4.bout), 32'(e.bout));
            checkOutput("dut4 busy in done", 32'(bus4.busy), 32'd0);
`ifdef SRS_SIGNED_OVF_EN
            checkOutput("dut4 ovf", 32'(bus4.ovf), 32'(e.ovf));
`endif
         end
      end
   end

   initial begin
      logic [N-1:0] prev_diff;
      int           guard;

      driveInputs(1, 1'b0, '0, '0, 1'b0);
      driveInputs(4, 1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);

      checkOutput("reset busy", 32'(bus1.busy), 32'd0);
      checkOutput("reset done", 32'(bus1.done), 32'd0);
      checkOutput("reset diff", 32'(bus1.diff), 32'd0);
      checkOutput("reset bout", 32'(bus1.bout), 32'd0);
      checkOutput("reset dut4 busy", 32'(bus4.busy), 32'd0);
      checkOutput("reset dut4 diff", 32'(bus4.diff), 32'd0);
`ifdef SRS_SIGNED_OVF_EN
      checkOutput("reset ovf", 32'(bus1.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed vectors, D=1");
      applyStimulus(1, 16'h1234, 16'h0034, 1'b0);
      waitDone(1, 16, "vec 1234-0034");
      applyStimulus(1, 16'h0000, 16'h0001, 1'b0);
      waitDone(1, 16, "vec 0000-0001");
      applyStimulus(1, 16'h8000, 16'h0000, 1'b1);
      waitDone(1, 16, "vec 8000-0000-1");
      prev_diff = 16'h7FFF;

      $display("[TB] start while busy is ignored, start in DONE is accepted");
      applyStimulus(1, 16'hA5A5, 16'h1111, 1'b1);
      repeat (4) @(negedge clk);
      driveInputs(1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
      checkOutput("diff held during run", 32'(bus1.diff), 32'(prev_diff));
      @(negedge clk);
      driveInputs(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      waitDone(1, 11, "ignored start");
      applyStimulus(1, 16'h0100, 16'h0200, 1'b0);
      waitDone(1, 16, "back-to-back");

      $display("[TB] reset during run");
      applyStimulus(1, 16'h4321, 16'h1234, 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(bus1.busy), 32'd0);
      checkOutput("abort done", 32'(bus1.done), 32'd0);
      checkOutput("abort diff", 32'(bus1.diff), 32'd0);
      checkOutput("abort bout", 32'(bus1.bout), 32'd0);
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("no done after abort", 32'(bus1.done), 32'd0);
      applyStimulus(1, 16'h00FF, 16'h0F00, 1'b1);
      waitDone(1, 16, "after abort");
      @(negedge clk);

      $display("[TB] directed vector, D=4");
      applyStimulus(4, 16'hFFFF, 16'hFFFF, 1'b1);
      waitDone(4, 4, "d4 FFFF-FFFF-1");
      @(negedge clk);

      $display("[TB] random vectors");
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
               applyStimulus(1, pickOperand(), pickOperand(), 1'($urandom));
            end
         end
         begin
            for (int j = 0; j < 1000; j++) begin
               if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
               applyStimulus(4, pickOperand(), pickOperand(), 1'($urandom));
            end
         end
      join

      guard = 0;
      while ((q1.size() != 0 || q4.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("dut1 queue drained", 32'(q1.size()), 32'd0);
      checkOutput("dut4 queue drained", 32'(q4.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
